// File: rtl/ctrl_pipeline.sv
// Control unit for the five-stage RV32 core: decodes the ID instruction into a control bundle and
// carries it through ID/EX, EX/MEM and MEM/WB, with load-use and multi-cycle mul/div stalling.
module ctrl_pipeline #(
  parameter int MULDIV_LAT = 4,
  parameter int RA_W       = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     inst_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [1:0]      ex_alu_op_o,
  output logic            ex_alu_src_o,
  output logic            ex_branch_o,
  output logic            ex_jump_o,
  output logic            ex_lui_o,
  output logic            ex_muldiv_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic            ex_mem_read_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic [RA_W-1:0] mem_rd_o,
  output logic            mem_reg_write_o,
  output logic            wb_reg_write_o,
  output logic [1:0]      wb_sel_o,
  output logic [RA_W-1:0] wb_rd_o
);

  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  typedef struct packed {
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            lui;
    logic            muldiv;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic [RA_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic [RA_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic [RA_W-1:0] rd;
  } memwb_t;

  idex_t      dec;
  idex_t      idex_q, idex_d;
  exmem_t     exmem_q, exmem_d;
  memwb_t     memwb_q, memwb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [RA_W-1:0] rd_f, rs1_f, rs2_f;
  logic            valid, uses_rs2, load_use, hold;
  logic            unused_funct3;

  assign rd_f  = RA_W'(inst_i[11:7]);
  assign rs1_f = RA_W'(inst_i[19:15]);
  assign rs2_f = RA_W'(inst_i[24:20]);
  assign unused_funct3 = ^inst_i[14:12];

  always_comb begin
    dec      = '0;
    valid    = 1'b1;
    uses_rs2 = 1'b0;
    unique case (inst_i[6:0])
      7'b0110011: begin
        dec.alu_op    = 2'b11;
        dec.reg_write = 1'b1;
        dec.muldiv    = (inst_i[31:25] == 7'b0000001);
        uses_rs2      = 1'b1;
      end
      7'b0010011: begin
        dec.alu_op    = 2'b01;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      7'b0000011: begin
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_sel    = 2'b01;
      end
      7'b0100011: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rs2      = 1'b1;
      end
      7'b1100011: begin
        dec.alu_op    = 2'b10;
        dec.branch    = 1'b1;
        uses_rs2      = 1'b1;
      end
      7'b1101111, 7'b1100111: begin
        dec.alu_src   = inst_i[3] ? 1'b0 : 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_sel    = 2'b10;
      end
      7'b0110111: begin
        dec.alu_src   = 1'b1;
        dec.lui       = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: valid = 1'b0;
    endcase
    // Bubbles keep rd at zero; writes to x0 are suppressed at decode.
    if (valid) dec.rd = rd_f;
    if (dec.rd == '0) dec.reg_write = 1'b0;
  end

  assign hold     = (cnt_q != '0);
  assign load_use = idex_q.mem_read && (idex_q.rd != '0) && valid &&
                    ((idex_q.rd == rs1_f) || (uses_rs2 && (idex_q.rd == rs2_f)));
  assign stall_o  = hold | (load_use & ~flush_i);

  always_comb begin
    idex_d = dec;
    cnt_d  = cnt_q;
    if (hold) begin
      idex_d = idex_q;
      cnt_d  = cnt_q - CNT_W'(1);
    end else if (flush_i || load_use) begin
      idex_d = '0;
    end else if (dec.muldiv) begin
      cnt_d = CNT_W'(MULDIV_LAT - 1);
    end

    exmem_d = '0;
    if (!hold) begin
      exmem_d.mem_read  = idex_q.mem_read;
      exmem_d.mem_write = idex_q.mem_write;
      exmem_d.reg_write = idex_q.reg_write;
      exmem_d.wb_sel    = idex_q.wb_sel;
      exmem_d.rd        = idex_q.rd;
    end

    memwb_d.reg_write = exmem_q.reg_write;
    memwb_d.wb_sel    = exmem_q.wb_sel;
    memwb_d.rd        = exmem_q.rd;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_alu_op_o     = idex_q.alu_op;
  assign ex_alu_src_o    = idex_q.alu_src;
  assign ex_branch_o     = idex_q.branch;
  assign ex_jump_o       = idex_q.jump;
  assign ex_lui_o        = idex_q.lui;
  assign ex_muldiv_o     = idex_q.muldiv;
  assign ex_rd_o         = idex_q.rd;
  assign ex_mem_read_o   = idex_q.mem_read;
  assign mem_read_o      = exmem_q.mem_read;
  assign mem_write_o     = exmem_q.mem_write;
  assign mem_rd_o        = exmem_q.rd;
  assign mem_reg_write_o = exmem_q.reg_write;
  assign wb_reg_write_o  = memwb_q.reg_write;
  assign wb_sel_o        = memwb_q.wb_sel;
  assign wb_rd_o         = memwb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: expected EX bundles are queued as each instruction is driven
// and popped after the clock edge; MEM/WB expectations trail the expected EX bundles.
module tb_ctrl_pipeline;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] inst_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic [1:0]  ex_alu_op_o;
  logic        ex_alu_src_o, ex_branch_o, ex_jump_o, ex_lui_o, ex_muldiv_o;
  logic [4:0]  ex_rd_o;
  logic        ex_mem_read_o;
  logic        mem_read_o, mem_write_o;
  logic [4:0]  mem_rd_o;
  logic        mem_reg_write_o;
  logic        wb_reg_write_o;
  logic [1:0]  wb_sel_o;
  logic [4:0]  wb_rd_o;

  always #5 clk_i = ~clk_i;

  ctrl_pipeline #(.MULDIV_LAT(4), .RA_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .flush_i(flush_i), .stall_o(stall_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o), .ex_branch_o(ex_branch_o),
    .ex_jump_o(ex_jump_o), .ex_lui_o(ex_lui_o), .ex_muldiv_o(ex_muldiv_o),
    .ex_rd_o(ex_rd_o), .ex_mem_read_o(ex_mem_read_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_rd_o(mem_rd_o),
    .mem_reg_write_o(mem_reg_write_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_sel_o(wb_sel_o), .wb_rd_o(wb_rd_o)
  );

  // hold: the mul/div counter is nonzero while this bundle sits in EX
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src, branch, jump, lui, muldiv, mem_read, mem_write, reg_write;
    logic [1:0] wb_sel;
    logic [4:0] rd;
    logic       hold;
  } tok_t;

  int   n_vec = 0;
  int   n_bad = 0;
  tok_t exp_q[$];
  tok_t prev_ex = '0;
  tok_t prev_mem = '0;

  function automatic tok_t tk(input logic [1:0] alu, input logic src, input logic br,
                              input logic jmp, input logic lu, input logic md, input logic mr,
                              input logic mw, input logic rw, input logic [1:0] wbs,
                              input logic [4:0] rd, input logic hd);
    tok_t t;
    t = '{alu_op: alu, alu_src: src, branch: br, jump: jmp, lui: lu, muldiv: md,
          mem_read: mr, mem_write: mw, reg_write: rw, wb_sel: wbs, rd: rd, hold: hd};
    return t;
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ex_obs();
    return 32'({ex_alu_op_o, ex_alu_src_o, ex_branch_o, ex_jump_o, ex_lui_o, ex_muldiv_o,
                ex_mem_read_o, ex_rd_o});
  endfunction

  function automatic logic [31:0] ex_exp(input tok_t t);
    return 32'({t.alu_op, t.alu_src, t.branch, t.jump, t.lui, t.muldiv, t.mem_read, t.rd});
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex"}, ex_obs(), 32'd0);
    chk({tag, "_memwb"}, 32'({mem_read_o, mem_write_o, mem_reg_write_o, mem_rd_o,
                              wb_reg_write_o, wb_sel_o, wb_rd_o}), 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
  endtask

  task automatic cyc(input logic [31:0] inst, input logic flush, input logic exp_stall,
                     input tok_t exp_ex);
    tok_t e, m;
    @(negedge clk_i);
    inst_i  = inst;
    flush_i = flush;
    exp_q.push_back(exp_ex);
    #1 chk("stall", 32'(stall_o), 32'(exp_stall));
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    m = prev_ex.hold ? '0 : prev_ex;
    chk("ex", ex_obs(), ex_exp(e));
    chk("mem", 32'({mem_read_o, mem_write_o, mem_reg_write_o, mem_rd_o}),
        32'({m.mem_read, m.mem_write, m.reg_write, m.rd}));
    chk("wb", 32'({wb_reg_write_o, wb_sel_o, wb_rd_o}),
        32'({prev_mem.reg_write, prev_mem.wb_sel, prev_mem.rd}));
    $display("inst=%08h flush=%b stall=%b ex_op=%b ex_md=%b ex_rd=%0d mem_rd=%0d wb_rd=%0d",
             inst, flush, stall_o, ex_alu_op_o, ex_muldiv_o, ex_rd_o, mem_rd_o, wb_rd_o);
    prev_mem = m;
    prev_ex  = e;
  endtask

  localparam logic [31:0] NOP  = 32'd0;
  localparam logic [31:0] LW5  = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] LW0  = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] ADDI = {12'd5, 5'd1, 3'b000, 5'd4, 7'b0010011};
  localparam logic [31:0] SW   = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] BEQ  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] JAL  = {20'd0, 5'd1, 7'b1101111};
  localparam logic [31:0] JALR = {12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111};
  localparam logic [31:0] LUI  = {20'd1, 5'd10, 7'b0110111};

  initial begin
    logic [31:0] add3, add6, add6z, add8, mul7, mul9;
    tok_t bub, t_add3, t_add6, t_add8, t_lw5, t_lw0, t_mul7h, t_mul7, t_mul9h;
    add3  = rtype(7'd0, 5'd2, 5'd1, 5'd3);
    add6  = rtype(7'd0, 5'd2, 5'd5, 5'd6);
    add6z = rtype(7'd0, 5'd2, 5'd0, 5'd6);
    add8  = rtype(7'd0, 5'd2, 5'd1, 5'd8);
    mul7  = rtype(7'd1, 5'd2, 5'd1, 5'd7);
    mul9  = rtype(7'd1, 5'd1, 5'd7, 5'd9);
    bub     = '0;
    t_add3  = tk(2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd3, 0);
    t_add6  = tk(2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd6, 0);
    t_add8  = tk(2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd8, 0);
    t_lw5   = tk(2'b00, 1, 0, 0, 0, 0, 1, 0, 1, 2'b01, 5'd5, 0);
    t_lw0   = tk(2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 2'b01, 5'd0, 0);
    t_mul7h = tk(2'b11, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 5'd7, 1);
    t_mul7  = tk(2'b11, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 5'd7, 0);
    t_mul9h = tk(2'b11, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 5'd9, 1);

    // Reset held with an R-type in ID
    inst_i = add3;
    #3 chk_all_zero("reset");
    @(posedge clk_i);
    #1 chk_all_zero("reset_edge");
    rst_i = 1'b1;

    // Basic propagation of add x3,x1,x2
    cyc(add3, 0, 0, t_add3);
    cyc(NOP,  0, 0, bub);
    cyc(NOP,  0, 0, bub);

    // Load-use: one stall, one bubble; load to x0 never stalls
    cyc(LW5,   0, 0, t_lw5);
    cyc(add6,  0, 1, bub);
    cyc(add6,  0, 0, t_add6);
    cyc(LW0,   0, 0, t_lw0);
    cyc(add6z, 0, 0, t_add6);

    // mul x7 occupies EX for 4 cycles; flush during the hold is ignored
    cyc(mul7, 0, 0, t_mul7h);
    cyc(add8, 0, 1, t_mul7h);
    cyc(add8, 1, 1, t_mul7h);
    cyc(add8, 0, 1, t_mul7);
    cyc(add8, 0, 0, t_add8);

    // Flush overrides a load-use pattern
    cyc(LW5,  0, 0, t_lw5);
    cyc(add6, 1, 0, bub);
    cyc(NOP,  0, 0, bub);

    // Back-to-back mul/div: second waits in ID, then reloads the counter
    cyc(mul7, 0, 0, t_mul7h);
    cyc(mul9, 0, 1, t_mul7h);
    cyc(mul9, 0, 1, t_mul7h);
    cyc(mul9, 0, 1, t_mul7);
    cyc(mul9, 0, 0, t_mul9h);
    cyc(NOP,  0, 1, t_mul9h);

    // Reset asserted in the second hold cycle clears everything at once
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk_all_zero("midhold_reset");
    @(posedge clk_i);
    #1 chk_all_zero("midhold_reset_edge");
    rst_i    = 1'b1;
    inst_i   = add3;
    prev_ex  = '0;
    prev_mem = '0;
    exp_q.delete();
    cyc(add3, 0, 0, t_add3);

    // Remaining opcode classes
    cyc(ADDI, 0, 0, tk(2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd4, 0));
    cyc(SW,   0, 0, tk(2'b00, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 5'd0, 0));
    cyc(BEQ,  0, 0, tk(2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 0));
    cyc(JAL,  0, 0, tk(2'b00, 0, 0, 1, 0, 0, 0, 0, 1, 2'b10, 5'd1, 0));
    cyc(JALR, 0, 0, tk(2'b00, 1, 0, 1, 0, 0, 0, 0, 1, 2'b10, 5'd1, 0));
    cyc(LUI,  0, 0, tk(2'b00, 1, 0, 0, 1, 0, 0, 0, 1, 2'b00, 5'd10, 0));
    cyc(NOP,  0, 0, bub);
    cyc(NOP,  0, 0, bub);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Pipelined control unit for the five-stage RV32 core: decodes the ID-stage instruction into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and a parametrised multi-cycle multiply/divide occupancy of EX, issuing the PC/IF-ID stall and inserting bubbles. It replaces the flat combinational decoder; datapath registers stay outside and follow `stall_o`.

## Interface
- `MULDIV_LAT`, 4: cycles an M-extension op occupies EX (≥1).
- `RA_W`, 5: register-address width.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `inst_i` in 32: instruction in ID.
- `flush_i` in 1: ID instruction is wrong-path; decode as bubble.
- `stall_o` out 1: hold PC and IF/ID this cycle.
- `ex_alu_op_o` out 2, `ex_alu_src_o` out 1, `ex_branch_o` out 1, `ex_jump_o` out 1, `ex_lui_o` out 1, `ex_muldiv_o` out 1: EX controls.
- `ex_rd_o` out RA_W, `ex_mem_read_o` out 1: EX destination and load flag.
- `mem_read_o` out 1, `mem_write_o` out 1, `mem_rd_o` out RA_W, `mem_reg_write_o` out 1: MEM controls and forwarding info.
- `wb_reg_write_o` out 1, `wb_sel_o` out 2 (00 ALU, 01 memory, 10 PC+4), `wb_rd_o` out RA_W: WB controls.

## Operation
- Decode on full opcode `inst_i[6:0]`, rd=`[11:7]`, rs1=`[19:15]`, rs2=`[24:20]`:
  - 0110011 R: alu_op 11, src 0, reg_write 1; muldiv=1 when `[31:25]`=0000001.
  - 0010011 I-ALU: alu_op 01, src 1, reg_write 1.
  - 0000011 load: alu_op 00, src 1, mem_read 1, reg_write 1, wb_sel 01.
  - 0100011 store: alu_op 00, src 1, mem_write 1.
  - 1100011 branch: alu_op 10, src 0, branch 1.
  - 1101111 JAL / 1100111 JALR: jump 1, reg_write 1, wb_sel 10; JALR src 1.
  - 0110111 LUI: src 1, lui 1, reg_write 1.
  - Anything else, incl. all-zero: bubble (all fields 0).
- reg_write forced 0 when rd=0; rd field forced 0 in bubbles.
- Load-use: `ex_mem_read_o` and `ex_rd_o`≠0 and `ex_rd_o` equals rs1 or rs2 of the decoded ID instruction (rs2 only for R/store/branch) → stall; ID/EX loads bubble.
- Multi-cycle: counter loaded with MULDIV_LAT-1 when a muldiv enters ID/EX. While counter≠0: ID/EX holds, EX/MEM loads bubble, counter decrements, stall. At 0 the op advances normally.
- `stall_o` = (counter≠0) | (load-use & ~flush_i).
- Priority at ID/EX: hold (counter≠0) > flush_i bubble > load-use bubble > decoded bundle. `flush_i` ignored while holding.
- EX/MEM and MEM/WB advance every cycle; never stall.

## Timing
- Reset (async, `rst_i`=0): all pipeline fields, counter and every output 0; `stall_o`=0 via zeroed state.
- Instruction decoded in cycle N appears on `ex_*` in N+1, `mem_*` in N+2, `wb_*` in N+3 (MULDIV adds MULDIV_LAT-1 at EX).
- `stall_o` combinational from registered EX state and `inst_i`; valid same cycle.
- MULDIV_LAT=1: counter never loaded, no stall.
- Load followed by muldiv-dependent op: load-use stall then normal muldiv occupancy, no overlap (load leaves EX first).
- Back-to-back muldiv: second decoded while first holds (stall_o=1, IF/ID stable); enters EX the cycle the first leaves, counter reloads.
- Reset mid-hold: counter cleared, bubbles everywhere, next edge decodes `inst_i` fresh.

## Test plan
- Reset: drive `rst_i`=0 with R-type on `inst_i` → all outputs 0; release → `ex_alu_op_o`=11, `ex_rd_o`=rd next edge.
- `add x3,x1,x2` → `ex_alu_op_o`=11 at N+1, `mem_reg_write_o`=1/`mem_rd_o`=3 at N+2, `wb_reg_write_o`=1/`wb_sel_o`=00 at N+3.
- `lw x5,0(x1)` then `add x6,x5,x2` → `stall_o`=1 one cycle, one bubble in EX, add in EX two cycles after lw; with rd=x0 → no stall.
- `mul x7,x1,x2`, MULDIV_LAT=4 → `ex_muldiv_o`=1 for 4 cycles, `stall_o`=1 for 3, three bubbles on `mem_*`, then `mem_rd_o`=7.
- `flush_i`=1 with load-use pattern in ID → `stall_o`=0, EX bubble next cycle; `flush_i`=1 during mul hold → ID/EX unchanged.
- `rst_i` pulsed low at second cycle of mul hold → counter 0, `stall_o`=0, all `ex_*/mem_*/wb_*` 0 immediately.
